// File: rtl/pipe_pkg.sv
// Shared definitions for the back-pressured pipeline stage register:
// default widths, stage occupancy state and the default-width entry layout.
package pipe_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_W   = 3;

    // Stage state doubles as the number of entries held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Entry layout at default widths; wider instances build the same
    // {regwrite, rd, data} shape from their own parameters.
    typedef struct packed {
        logic                  regwrite;
        logic [DEF_RD_W-1:0]   rd;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

    localparam int DEF_ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid-qualified entry register. Load sets valid and captures the
// entry; clear only drops valid so the held payload never toggles when
// the slot empties (payload of an empty slot is don't-care).
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = DEF_ENTRY_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid flag: load wins over clear so a same-cycle refill stays valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload register: only written on load, zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// EX->WB stage register with valid/ready handshake, a two-entry skid
// buffer (OUT + SKID) for full throughput under stall, synchronous flush
// and a forwarding view of the output slot. in_ready is a flop so there is
// no combinational path from out_ready back upstream.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              fwd_valid,
    output logic [1:0]        occupancy
);

    localparam int ENT_W = 1 + RD_W + DATA_W;

    typedef struct packed {
        logic              regwrite;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    stage_state_e state, state_nxt;

    logic accept, consume;
    logic out_load, out_clr, skid_load, skid_clr, out_from_skid;
    logic out_vld, skid_vld;
    ent_t in_ent, out_d, out_q, skid_q;

    assign in_ent  = {in_regwrite, in_rd, in_data};
    assign accept  = in_valid & in_ready;
    assign consume = out_vld & out_ready;

    // OUT refills from SKID when draining FULL, otherwise from the input.
    assign out_d = out_from_skid ? skid_q : in_ent;

    pipe_slot #(.W(ENT_W)) u_out (
        .clk   (clk),
        .rstn  (rstn),
        .load  (out_load),
        .clear (out_clr),
        .d     (out_d),
        .valid (out_vld),
        .q     (out_q)
    );

    pipe_slot #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_ent),
        .valid (skid_vld),
        .q     (skid_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and slot controls; flush overrides everything and drops
    // any same-cycle accept (a coincident consume is already delivered).
    always_comb begin
        state_nxt     = state;
        out_load      = 1'b0;
        out_clr       = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            out_clr   = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        out_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        out_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_nxt = EMPTY;
                        out_clr   = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a consume can move us.
                    if (consume) begin
                        state_nxt     = ONE;
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    out_clr   = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Ready flop: open whenever the next state leaves room for an entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (state_nxt != FULL);
        end
    end

    // Output view; regwrite is gated so an empty slot never forwards.
    assign out_valid    = out_vld;
    assign out_regwrite = out_vld & out_q.regwrite;
    assign out_rd       = out_q.rd;
    assign out_data     = out_q.data;
    assign fwd_valid    = out_regwrite;
    assign occupancy    = {1'b0, out_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid at DATA_W=32, RD_W=5. Expected entries are
// queued when the stage accepts them and popped by an independent monitor
// when the stage delivers; the queue itself is the reference model of what
// the stage holds (occupancy, ready, output slot contents).
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_regwrite;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_regwrite;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic          fwd_valid;
    logic [1:0]    occupancy;

    pipe_stage_skid #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_regwrite  (in_regwrite),
        .in_rd        (in_rd),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_regwrite (out_regwrite),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .fwd_valid    (fwd_valid),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   run    = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    // Stimulus side: every accepted entry becomes an expected delivery.
    always @(posedge clk) begin
        if (rstn && in_valid && in_ready && !flush)
            exp_q.push_back('{in_regwrite, in_rd, in_data});
    end

    // Delivery monitor: each consume must match the oldest undelivered
    // entry; flush then discards whatever is still held.
    always @(posedge clk) begin
        ent_t e;
        if (rstn) begin
            if (out_valid && out_ready) begin
                chk("deliver_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("deliver_rd", out_rd, e.rd);
                    chk("deliver_data", out_data, e.data);
                    chk("deliver_regwrite", out_regwrite, e.rw);
                end
            end
            if (flush) exp_q.delete();
        end
    end

    // Held-state view: entries held = accepted minus delivered, at most two;
    // the output slot shows the oldest one and must stay put until consumed.
    always @(negedge clk) begin
        if (rstn && run) begin
            chk("occupancy", occupancy, exp_q.size());
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("out_rd", out_rd, exp_q[0].rd);
                chk("out_data", out_data, exp_q[0].data);
                chk("out_regwrite", out_regwrite, exp_q[0].rw);
                chk("fwd_valid", fwd_valid, exp_q[0].rw);
            end else begin
                chk("idle_regwrite", out_regwrite, 0);
                chk("idle_fwd_valid", fwd_valid, 0);
            end
        end
    end

    task automatic cyc(input logic v, input logic rw, input logic [RW-1:0] rd,
                       input logic [DW-1:0] d, input logic ordy, input logic fl);
        in_valid    = v;
        in_regwrite = rw;
        in_rd       = rd;
        in_data     = d;
        out_ready   = ordy;
        flush       = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_regwrite"}, out_regwrite, 0);
        chk({tag, "_out_rd"}, out_rd, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_fwd_valid"}, fwd_valid, 0);
        chk({tag, "_occupancy"}, occupancy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0;
        in_rd = '0; in_data = '0; out_ready = 1'b0;
        #1 rstn = 1'b0;
        #2 chk_reset("reset");
        @(negedge clk);
        rstn = 1'b1;
        run  = 1'b1;

        // Streaming: back-to-back with the sink always ready.
        for (int i = 1; i <= 5; i++)
            cyc(1'b1, 1'b1, RW'(i), DW'(32'h10 + i - 1), 1'b1, 1'b0);
        chk("stream_last_data", out_data, 32'h14);
        chk("stream_occ", occupancy, 1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("stream_drained", out_valid, 0);

        // Stall: second entry lands in the skid, then ready drops.
        cyc(1'b1, 1'b1, 5'd2, 32'hAA, 1'b0, 1'b0);
        chk("stall_ready_one", in_ready, 1);
        cyc(1'b1, 1'b1, 5'd3, 32'hBB, 1'b0, 1'b0);
        chk("stall_occ_full", occupancy, 2);
        chk("stall_ready_full", in_ready, 0);
        chk("stall_out_data", out_data, 32'hAA);
        cyc(1'b1, 1'b1, 5'd7, 32'hEE, 1'b0, 1'b0);
        chk("stall_hold_rd", out_rd, 2);
        chk("stall_hold_data", out_data, 32'hAA);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("release_ready", in_ready, 1);
        chk("release_out_data", out_data, 32'hBB);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("release_empty", occupancy, 0);

        // Flush from FULL with an entry offered.
        cyc(1'b1, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd4, 32'h55, 1'b0, 1'b1);
        chk("flush_full_valid", out_valid, 0);
        chk("flush_full_occ", occupancy, 0);
        chk("flush_full_ready", in_ready, 1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_no_55", out_valid, 0);

        // Flush from ONE: the same-cycle accept is dropped, the consume counts.
        cyc(1'b1, 1'b1, 5'd1, 32'h33, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd4, 32'h55, 1'b1, 1'b1);
        chk("flush_one_valid", out_valid, 0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_one_occ", occupancy, 0);

        // Bubble entry travels but does not forward.
        cyc(1'b1, 1'b0, 5'd5, 32'h77, 1'b0, 1'b0);
        chk("bubble_valid", out_valid, 1);
        chk("bubble_regwrite", out_regwrite, 0);
        chk("bubble_fwd", fwd_valid, 0);
        chk("bubble_data", out_data, 32'h77);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset while FULL, between clock edges.
        cyc(1'b1, 1'b1, 5'd1, 32'hC1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd2, 32'hC2, 1'b0, 1'b0);
        chk("pre_rst_occ", occupancy, 2);
        #2 rstn = 1'b0;
        in_valid = 1'b0;
        #1 chk_reset("rst_mid");
        exp_q.delete();
        #1 rstn = 1'b1;
        cyc(1'b1, 1'b1, 5'd6, 32'h01, 1'b0, 1'b0);
        chk("post_rst_rd", out_rd, 6);
        chk("post_rst_data", out_data, 32'h01);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), RW'($urandom),
                $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        repeat (4) cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("final_drained", exp_q.size(), 0);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, back-pressure-capable pipeline stage register for the EX→WB boundary (reusable at any stage boundary) that carries a regwrite flag, destination register index and result payload. It adds a valid/ready handshake, a two-entry skid buffer for full throughput under stall, a synchronous flush, and a forwarding view of the output slot for the hazard/forwarding unit. It replaces the fixed-width, always-advancing stage register between the ALU and the register-file write port.

## Interface
- DATA_W, 8, result payload width
- RD_W, 3, destination register index width
- clk  input  1  clock, all state on rising edge
- rstn  input  1  reset rstn, asynchronous, active-low
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream presents an entry
- in_ready  output  1  stage can accept (registered)
- in_regwrite  input  1  entry writes register file
- in_rd  input  RD_W  destination index
- in_data  input  DATA_W  result payload
- out_valid  output  1  output slot holds an entry
- out_ready  input  1  downstream (WB) consumes this cycle
- out_regwrite  output  1  regwrite of output slot, forced 0 when !out_valid
- out_rd  output  RD_W  destination index of output slot
- out_data  output  DATA_W  payload of output slot
- fwd_valid  output  1  out_valid & out_regwrite, for forwarding comparator
- occupancy  output  2  entries held, 0..2

## Operation
- Two slots: OUT (drives outputs) and SKID (overflow). State EMPTY (0), ONE (OUT valid), FULL (OUT+SKID valid).
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- EMPTY: accept → ONE, entry into OUT.
- ONE: accept & consume → ONE, new entry into OUT; accept & !consume → FULL, entry into SKID; !accept & consume → EMPTY; else hold.
- FULL: consume → ONE, SKID moves to OUT; in_ready is 0 so no accept possible.
- in_ready = (next state != FULL), registered; equals 1 in EMPTY/ONE, 0 in FULL.
- flush highest priority: next state EMPTY, any same-cycle accept discarded, in_ready 1 next cycle. A consume coincident with flush still counts as delivered in that cycle.
- Entries with in_regwrite=0 travel normally (bubble/store result); only out_regwrite is gated.
- Payload of invalid slots is don't-care but must not toggle out_data while out_valid & !out_ready.

## Timing
- Reset (rstn low, async): state EMPTY, out_valid 0, out_regwrite 0, out_rd 0, out_data 0, fwd_valid 0, occupancy 0, in_ready 1.
- Latency: accept at edge N → out_valid/out_* valid after edge N (visible cycle N+1).
- Throughput: one entry per cycle with out_ready held 1; no bubble inserted.
- Stall: out_* stable while out_valid & !out_ready; at most one extra entry absorbed, then in_ready drops the cycle after FULL is entered.
- Release from FULL: in_ready returns 1 the cycle after the first consume.
- Reset mid-operation: both slots discarded immediately, no partial entry survives.
- No combinational path from out_ready to in_ready; in_ready is a flop output.

## Structure
- Shared package pipe_pkg: default DATA_W/RD_W, stage state enum (EMPTY/ONE/FULL), entry struct {regwrite, rd, data}.
- Sub-module pipe_slot: one valid-qualified entry register with load/clear, instanced for OUT and SKID.
- Top contains state register, mux SKID-vs-input into OUT, in_ready flop, output gating.

## Test plan
- Streaming: out_ready=1, send rd=1..5 data 0x10..0x14 back-to-back → identical sequence out one cycle later, in_ready never 0, occupancy ≤1.
- Stall: send rd=2/0xAA, rd=3/0xBB with out_ready=0 → occupancy 2, in_ready 0, out stays rd=2/0xAA; raise out_ready → 0xAA then 0xBB, in_ready 1 after first consume.
- Flush: FULL with two entries, pulse flush with in_valid=1 rd=4/0x55 → next cycle out_valid 0, occupancy 0, in_ready 1, 0x55 never appears.
- Bubble gating: entry in_regwrite=0 rd=5 data 0x77 → out_valid 1, out_regwrite 0, fwd_valid 0, out_data 0x77.
- Async reset mid-stall: FULL, drop rstn between edges → all outputs reset values immediately, in_ready 1; after release new entry rd=6/0x01 passes with 1-cycle latency.
- Parameter sweep: DATA_W=32, RD_W=5, random in_valid/out_ready → scoreboard in-order, no loss/duplication, out stable under stall.
